// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register in-flight writer tracking with load-use stall and forwarding select
module hazard_scoreboard #(
   parameter int REG_ADDR_W = 5,
   parameter int PIPE_DEPTH = 3,
   parameter int LOAD_LATENCY = 2,
   localparam int FWD_W = $clog2(PIPE_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  issue_valid,
   input  logic                  issue_we,
   input  logic                  issue_load,
   input  logic [REG_ADDR_W-1:0] issue_waddr,
   input  logic [REG_ADDR_W-1:0] rs_addr,
   input  logic [REG_ADDR_W-1:0] rt_addr,
   input  logic                  rs_used,
   input  logic                  rt_used,
   input  logic                  flush,
   output logic                  stall,
   output logic [FWD_W-1:0]      rs_fwd,
   output logic [FWD_W-1:0]      rt_fwd,
   output logic [31:0]           stall_count
);
   localparam int NREG = 2**REG_ADDR_W;
   localparam logic [FWD_W:0] PD = PIPE_DEPTH[FWD_W:0];
   localparam logic [FWD_W:0] LL = LOAD_LATENCY[FWD_W:0];
   logic [NREG-1:0]  valid;
   logic [NREG-1:0]  is_load;
   logic [FWD_W-1:0] age [NREG];
   logic             hazard_rs;
   logic             hazard_rt;
   logic             accept;
   // Hazard detection and forwarding select from pre-update state
   always_comb begin
      hazard_rs = rs_used & valid[rs_addr] & is_load[rs_addr] & ({1'b0, age[rs_addr]} < LL);
      hazard_rt = rt_used & valid[rt_addr] & is_load[rt_addr] & ({1'b0, age[rt_addr]} < LL);
      stall = issue_valid & (hazard_rs | hazard_rt) & ~flush;
      accept = issue_valid & ~stall & ~flush & issue_we & (issue_waddr != '0);
      rs_fwd = valid[rs_addr] ? age[rs_addr] : '0;
      rt_fwd = valid[rt_addr] ? age[rt_addr] : '0;
   end
   // Per-register writer tracking: younger writer overwrites, others age out after PIPE_DEPTH
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         valid <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (accept && issue_waddr == i[REG_ADDR_W-1:0]) begin
               valid[i] <= 1'b1;
               is_load[i] <= issue_load;
               age[i] <= FWD_W'(1);
            end else if (valid[i]) begin
               age[i] <= age[i] + 1'b1;
               if ({1'b0, age[i]} + 1'b1 == PD) valid[i] <= 1'b0;
            end
         end
      end
   end
   // Saturating count of stalled decode cycles
   always_ff @(posedge clk) begin
      if (rst) stall_count <= '0;
      else if (stall && ~&stall_count) stall_count <= stall_count + 1'b1;
   end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed checks of stall, forwarding and stall counting
module tb_hazard_scoreboard;
   logic        clk = 0;
   logic        rst = 1;
   logic        issue_valid = 0;
   logic        issue_we = 0;
   logic        issue_load = 0;
   logic [4:0]  issue_waddr = 0;
   logic [4:0]  rs_addr = 0;
   logic [4:0]  rt_addr = 0;
   logic        rs_used = 0;
   logic        rt_used = 0;
   logic        flush = 0;
   logic        stall;
   logic [1:0]  rs_fwd;
   logic [1:0]  rt_fwd;
   logic [31:0] stall_count;
   int          n_checks = 0;
   int          n_fail = 0;

   hazard_scoreboard dut (
      .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_we(issue_we),
      .issue_load(issue_load), .issue_waddr(issue_waddr), .rs_addr(rs_addr),
      .rt_addr(rt_addr), .rs_used(rs_used), .rt_used(rt_used), .flush(flush),
      .stall(stall), .rs_fwd(rs_fwd), .rt_fwd(rt_fwd), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic we, input logic ld, input logic [4:0] wa,
                        input logic [4:0] rs, input logic rsu, input logic [4:0] rt,
                        input logic rtu, input logic fl);
      issue_valid = v; issue_we = we; issue_load = ld; issue_waddr = wa;
      rs_addr = rs; rs_used = rsu; rt_addr = rt; rt_used = rtu; flush = fl;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 0;
      drive(1, 0, 0, 0, 8, 1, 0, 0, 0);
      check("reset_stall", stall, 0);
      check("reset_rs_fwd", rs_fwd, 0);
      check("reset_count", stall_count, 0);
      tick;
      drive(1, 1, 0, 8, 0, 0, 0, 0, 0);
      check("alu_c0_stall", stall, 0);
      tick;
      drive(1, 0, 0, 0, 8, 1, 0, 0, 0);
      check("alu_c1_fwd", rs_fwd, 1);
      check("alu_c1_stall", stall, 0);
      tick;
      check("alu_c2_fwd", rs_fwd, 2);
      tick;
      check("alu_c3_fwd", rs_fwd, 0);
      drive(1, 1, 1, 9, 0, 0, 0, 0, 0);
      tick;
      drive(1, 0, 0, 0, 0, 0, 9, 1, 0);
      check("lu_c1_stall", stall, 1);
      check("lu_c1_fwd", rt_fwd, 1);
      tick;
      check("lu_c2_stall", stall, 0);
      check("lu_c2_fwd", rt_fwd, 2);
      check("lu_c2_count", stall_count, 1);
      tick;
      drive(1, 1, 1, 9, 0, 0, 0, 0, 0);
      tick;
      drive(1, 0, 0, 0, 0, 0, 9, 0, 0);
      check("unused_stall", stall, 0);
      check("unused_fwd", rt_fwd, 1);
      tick;
      drive(1, 1, 1, 0, 0, 0, 0, 0, 0);
      tick;
      drive(1, 0, 0, 0, 0, 1, 0, 1, 0);
      check("r0_stall", stall, 0);
      check("r0_rs_fwd", rs_fwd, 0);
      check("r0_rt_fwd", rt_fwd, 0);
      tick;
      drive(1, 1, 1, 5, 0, 0, 0, 0, 0);
      tick;
      drive(1, 1, 0, 5, 0, 0, 0, 0, 0);
      tick;
      drive(1, 0, 0, 0, 5, 1, 0, 0, 0);
      check("ovw_fwd", rs_fwd, 1);
      check("ovw_stall", stall, 0);
      tick;
      drive(1, 1, 1, 7, 0, 0, 0, 0, 0);
      tick;
      drive(1, 0, 0, 0, 7, 1, 0, 0, 1);
      check("flush_stall", stall, 0);
      tick;
      drive(1, 0, 0, 0, 7, 1, 0, 0, 0);
      check("flush_fwd", rs_fwd, 0);
      check("flush_count", stall_count, 1);
      drive(1, 1, 1, 9, 0, 0, 0, 0, 0);
      tick;
      drive(1, 1, 0, 10, 9, 1, 0, 0, 0);
      check("gate_stall", stall, 1);
      tick;
      drive(1, 0, 0, 0, 10, 1, 0, 0, 0);
      check("gate_no_accept", rs_fwd, 0);
      check("gate_count", stall_count, 2);
      drive(1, 1, 1, 3, 0, 0, 0, 0, 0);
      tick;
      drive(1, 0, 0, 0, 3, 1, 0, 0, 0);
      check("rstmid_stall_before", stall, 1);
      rst = 1;
      tick;
      rst = 0;
      #1;
      check("rstmid_stall_after", stall, 0);
      check("rstmid_fwd", rs_fwd, 0);
      check("rstmid_count", stall_count, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
